// File: rtl/spi_slave_core.sv
// SPI slave endpoint: oversamples SCK/CS/MOSI in the I_clk domain, shifts one word in
// from MOSI and out on MISO in any CPOL/CPHA mode, with a valid/ready TX holding register
// and a done-pulse RX interface. Requires f(I_clk) >= 4*f(SCK).
// Optional feature macro: SPI_SLAVE_FRAME_ERR_EN adds O_frame_err (aborted word or TX
// underrun at a word load).
module spi_slave_core #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_cpol,
  input  logic              I_cpha,
  input  logic              I_spi_sck,
  input  logic              I_spi_cs,
  input  logic              I_spi_mosi,
  output logic              O_spi_miso,
  input  logic [DATA_W-1:0] I_tx_data,
  input  logic              I_tx_valid,
  output logic              O_tx_ready,
  output logic [DATA_W-1:0] O_rx_data,
  output logic              O_rx_done,
  output logic              O_busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic              O_frame_err
`endif
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StXfer} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]      rx_shreg_q, rx_shreg_d;
  logic [DATA_W-1:0]      tx_shreg_q, tx_shreg_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_done_q, rx_done_d;
  logic [DATA_W-1:0]      hold_q;
  logic                   hold_full_q;
  logic                   accept, load_fire, word_done;

  // Synchronise the asynchronous SPI pins; CS idles high so no spurious frame at reset.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], I_spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], I_spi_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], I_spi_mosi};
      sck_prev_q  <= sck_s;
    end
  end

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise    = sck_s & ~sck_prev_q;
  assign sck_fall    = ~sck_s & sck_prev_q;
  assign lead_edge   = I_cpol ? sck_fall : sck_rise;
  assign trail_edge  = I_cpol ? sck_rise : sck_fall;
  assign sample_edge = I_cpha ? trail_edge : lead_edge;
  assign shift_edge  = I_cpha ? lead_edge : trail_edge;

  assign load_fire = (state_q == StLoad) & ~cs_s;
  assign word_done = (state_q == StXfer) & sample_edge & (cnt_q == CntW'(DATA_W - 1));
  assign accept    = I_tx_valid & ~hold_full_q;

  // TX holding register; a load and an accept in the same cycle leave the new byte held.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      if (accept) begin
        hold_q      <= I_tx_data;
        hold_full_q <= 1'b1;
      end else if (load_fire) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  // Transfer state and datapath registers.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rx_shreg_q <= '0;
      tx_shreg_q <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_shreg_q <= rx_shreg_d;
      tx_shreg_q <= tx_shreg_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
    end
  end

  // Next-state: a shift edge with the counter at 0 starts a new word (LOAD), otherwise
  // it advances MISO; the sample edge is honoured even when CS rises in the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_shreg_d = rx_shreg_q;
    tx_shreg_d = tx_shreg_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d      = '0;
        rx_shreg_d = '0;
        tx_shreg_d = '0;
        if (!cs_s) state_d = I_cpha ? StXfer : StLoad;
      end
      StLoad: begin
        if (cs_s) begin
          state_d = StIdle;
        end else begin
          tx_shreg_d = hold_full_q ? hold_q : '0;
          state_d    = StXfer;
        end
      end
      StXfer: begin
        if (sample_edge) begin
          rx_shreg_d = {rx_shreg_q[DATA_W-2:0], mosi_s};
          cnt_d      = word_done ? '0 : cnt_q + CntW'(1);
          if (word_done) begin
            rx_data_d = {rx_shreg_q[DATA_W-2:0], mosi_s};
            rx_done_d = 1'b1;
          end
        end
        if (cs_s) begin
          state_d = StIdle;
        end else if (shift_edge) begin
          if (cnt_q == '0) state_d = StLoad;
          else tx_shreg_d = tx_shreg_q << 1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err_q;
  logic abort;

  assign abort = (state_q == StXfer) & cs_s & (cnt_q != '0) & ~word_done;

  // Flag aborted words and loads that found the holding register empty.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) frame_err_q <= 1'b0;
    else          frame_err_q <= abort | (load_fire & ~hold_full_q);
  end

  assign O_frame_err = frame_err_q;
`endif

  assign O_spi_miso = (state_q != StIdle) & tx_shreg_q[DATA_W-1];
  assign O_tx_ready = ~hold_full_q;
  assign O_rx_data  = rx_data_q;
  assign O_rx_done  = rx_done_q;
  assign O_busy     = ~cs_s;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: table vectors, hand-written corner sequences and randomized
// frames checked against a word-level model of what the master should see.
module tb_spi_slave_core;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpol, cpha, sck, cs, mosi, miso;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_done, busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       frame_err;
  int         err_pulses = 0;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_seen[$];

  always #5 clk = ~clk;

  spi_slave_core #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .I_clk      (clk),
    .I_rst_n    (rst_n),
    .I_cpol     (cpol),
    .I_cpha     (cpha),
    .I_spi_sck  (sck),
    .I_spi_cs   (cs),
    .I_spi_mosi (mosi),
    .O_spi_miso (miso),
    .I_tx_data  (tx_data),
    .I_tx_valid (tx_valid),
    .O_tx_ready (tx_ready),
    .O_rx_data  (rx_data),
    .O_rx_done  (rx_done),
    .O_busy     (busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .O_frame_err(frame_err)
`endif
  );

  typedef struct packed {
    logic            cpol;
    logic            cpha;
    logic [1:0]      nw;
    logic [1:0]      ntx;
    logic [2:0][7:0] mo;
    logic [2:0][7:0] tx;
    logic [2:0][7:0] exp_rx;
    logic [2:0][7:0] exp_miso;
    logic [1:0]      exp_done;
    logic [2:0]      exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // TX feeder: offers the next queued byte whenever the holding register is empty.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_valid) tx_valid = 1'b0;
      else if (tx_ready && tx_q.size() > 0) begin
        tx_data  = tx_q.pop_front();
        tx_valid = 1'b1;
      end
    end
  end

  // Monitor: records received words and error pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_done) rx_seen.push_back(rx_data);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      if (frame_err) err_pulses++;
`endif
    end
  end

  initial begin
    #800000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  // Master: shift n bits (MSB first) of mo, collecting MISO into mi.
  task automatic bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      if (!cpha) begin
        mosi = mo[i]; half(); mi[i] = miso; sck = ~cpol; half(); sck = cpol;
      end else begin
        sck = ~cpol; mosi = mo[i]; half(); mi[i] = miso; sck = cpol; half();
      end
    end
  endtask

  task automatic setup_mode(input logic pol, input logic pha);
    cpol = pol; cpha = pha; sck = pol; mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [7:0] got;
    cpol = v.cpol; cpha = v.cpha; sck = v.cpol; mosi = 1'b0;
    for (int k = 0; k < int'(v.ntx); k++) tx_q.push_back(v.tx[k]);
    repeat (8) @(negedge clk);
    rx_seen.delete();
`ifdef SPI_SLAVE_FRAME_ERR_EN
    err_pulses = 0;
`endif
    cs = 1'b0;
    half();
    check({tag, "_busy1"}, 32'(busy), 32'd1);
    for (int k = 0; k < int'(v.nw); k++) begin
      bits(v.mo[k], 8, got);
      check($sformatf("%s_miso%0d", tag, k), 32'(got), 32'(v.exp_miso[k]));
    end
    half(); cs = 1'b1; half(); half();
    check({tag, "_busy0"}, 32'(busy), 32'd0);
    check({tag, "_ndone"}, 32'(rx_seen.size()), 32'(v.exp_done));
    for (int k = 0; k < int'(v.nw); k++)
      check($sformatf("%s_rx%0d", tag, k),
            (k < rx_seen.size()) ? 32'(rx_seen[k]) : 32'hDEAD_BEEF, 32'(v.exp_rx[k]));
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check({tag, "_ferr"}, 32'(err_pulses), 32'(v.exp_err));
`endif
  endtask

  // Word-level model: master receives queued bytes in order, zeros once the queue runs dry;
  // CPHA=0 also loads once more on the final trailing edge, which always finds it empty.
  function automatic vec_t model(input logic pol, input logic pha, input int nw, input int ntx,
                                 input logic [2:0][7:0] mo, input logic [2:0][7:0] tx);
    vec_t v;
    v.cpol = pol; v.cpha = pha; v.nw = 2'(nw); v.ntx = 2'(ntx);
    v.mo = mo; v.tx = tx; v.exp_rx = mo;
    for (int k = 0; k < 3; k++) v.exp_miso[k] = (k < ntx) ? tx[k] : 8'h00;
    v.exp_done = 2'(nw);
    v.exp_err  = 3'((nw - ntx) + (pha ? 0 : 1));
    return v;
  endfunction

  initial begin
    logic [7:0] got;
    vec_t v;
    rst_n = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_rxdata", 32'(rx_data), 32'd0);
    check("rst_rxdone", 32'(rx_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    vecs[0] = '{cpol:1'b0, cpha:1'b0, nw:2'd1, ntx:2'd1, mo:{16'h0, 8'hA5}, tx:{16'h0, 8'h3C},
                exp_rx:{16'h0, 8'hA5}, exp_miso:{16'h0, 8'h3C}, exp_done:2'd1, exp_err:3'd1};
    vecs[1] = '{cpol:1'b0, cpha:1'b1, nw:2'd1, ntx:2'd1, mo:{16'h0, 8'h5A}, tx:{16'h0, 8'hC3},
                exp_rx:{16'h0, 8'h5A}, exp_miso:{16'h0, 8'hC3}, exp_done:2'd1, exp_err:3'd0};
    vecs[2] = '{cpol:1'b1, cpha:1'b0, nw:2'd1, ntx:2'd1, mo:{16'h0, 8'h5A}, tx:{16'h0, 8'hC3},
                exp_rx:{16'h0, 8'h5A}, exp_miso:{16'h0, 8'hC3}, exp_done:2'd1, exp_err:3'd1};
    vecs[3] = '{cpol:1'b1, cpha:1'b1, nw:2'd1, ntx:2'd1, mo:{16'h0, 8'h5A}, tx:{16'h0, 8'hC3},
                exp_rx:{16'h0, 8'h5A}, exp_miso:{16'h0, 8'hC3}, exp_done:2'd1, exp_err:3'd0};
    vecs[4] = '{cpol:1'b0, cpha:1'b0, nw:2'd2, ntx:2'd2, mo:{8'h0, 8'h02, 8'h01},
                tx:{8'h0, 8'h22, 8'h11}, exp_rx:{8'h0, 8'h02, 8'h01},
                exp_miso:{8'h0, 8'h22, 8'h11}, exp_done:2'd2, exp_err:3'd1};
    vecs[5] = '{cpol:1'b0, cpha:1'b0, nw:2'd1, ntx:2'd0, mo:{16'h0, 8'hFF}, tx:{24'h0},
                exp_rx:{16'h0, 8'hFF}, exp_miso:{24'h0}, exp_done:2'd1, exp_err:3'd2};
    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // rx_done lands exactly SYNC_STAGES+1 clocks after the last sample edge at the pin.
    setup_mode(1'b0, 1'b0);
    tx_q.push_back(8'h96);
    repeat (8) @(negedge clk);
    rx_seen.delete();
    cs = 1'b0; half();
    bits(8'h6B, 7, got);
    check("tim_miso", 32'(got[7:1]), 32'h4B);
    mosi = 1'b1; half(); sck = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("tim_early", 32'(rx_done), 32'd0);
    @(posedge clk);
    #1 check("tim_pulse", 32'(rx_done), 32'd1);
    check("tim_data", 32'(rx_data), 32'h6B);
    @(posedge clk);
    #1 check("tim_late", 32'(rx_done), 32'd0);
    @(negedge clk);
    sck = 1'b0; half(); cs = 1'b1; half(); half();

    // Abort after 5 bits: no word, data kept, unconsumed holding byte survives.
    tx_q.push_back(8'h77);
    repeat (8) @(negedge clk);
    rx_seen.delete();
`ifdef SPI_SLAVE_FRAME_ERR_EN
    err_pulses = 0;
`endif
    cs = 1'b0; half();
    tx_q.push_back(8'hE1);
    bits(8'hC4, 5, got);
    check("abort_miso", 32'(got[7:3]), 32'h0E);
    half(); cs = 1'b1; half(); half();
    check("abort_ndone", 32'(rx_seen.size()), 32'd0);
    check("abort_rxdata", 32'(rx_data), 32'h6B);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("abort_ferr", 32'(err_pulses), 32'd1);
`endif
    v = '{cpol:1'b0, cpha:1'b0, nw:2'd1, ntx:2'd0, mo:{16'h0, 8'h3D}, tx:{24'h0},
          exp_rx:{16'h0, 8'h3D}, exp_miso:{16'h0, 8'hE1}, exp_done:2'd1, exp_err:3'd1};
    run_frame(v, "postabort");

    // Reset mid-word in mode 3.
    setup_mode(1'b1, 1'b1);
    tx_q.push_back(8'hAA);
    repeat (8) @(negedge clk);
    cs = 1'b0; half();
    bits(8'h12, 3, got);
    rst_n = 1'b0;
    #1;
    check("mrst_miso", 32'(miso), 32'd0);
    check("mrst_ready", 32'(tx_ready), 32'd1);
    check("mrst_rxdata", 32'(rx_data), 32'd0);
    check("mrst_rxdone", 32'(rx_done), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("mrst_ferr", 32'(frame_err), 32'd0);
`endif
    tx_q.delete(); tx_valid = 1'b0; cs = 1'b1; sck = cpol;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    v = '{cpol:1'b1, cpha:1'b1, nw:2'd1, ntx:2'd1, mo:{16'h0, 8'h81}, tx:{16'h0, 8'h5C},
          exp_rx:{16'h0, 8'h81}, exp_miso:{16'h0, 8'h5C}, exp_done:2'd1, exp_err:3'd0};
    run_frame(v, "postrst");

    // Randomized frames against the word-level model.
    for (int r = 0; r < 12; r++) begin
      logic [2:0][7:0] mo, tx;
      int nw, ntx;
      nw  = int'($urandom_range(1, 3));
      ntx = int'($urandom_range(0, nw));
      for (int k = 0; k < 3; k++) begin
        mo[k] = 8'($urandom());
        tx[k] = 8'($urandom());
      end
      v = model(1'($urandom()), 1'($urandom()), nw, ntx, mo, tx);
      run_frame(v, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
